iomem_arbiter: RTL and testbench

//  Shares the picosoc iomem bus between two masters: m0 = CPU iomem port, m1 = auxiliary master (DMA / LED sequencer).

---
 rtl/picosoc_bus_pkg.sv | 27 ++
 rtl/iomem_rr_pick.sv | 26 ++
 rtl/iomem_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_iomem_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/picosoc_bus_pkg.sv
// Package picosoc_bus_pkg
// Purpose: shared definitions for the picosoc iomem bus arbiter.
//   - iomem bus widths (address, data, byte strobe)
//   - master index constants and one-hot grant codes
//   - arbiter state encoding
// Ports: none (package).
package picosoc_bus_pkg;

  localparam int IOMEM_AW = 32;
  localparam int IOMEM_DW = 32;
  localparam int IOMEM_SW = 4;

  // Master indices; the bit positions of the one-hot grant vector
  localparam int M0 = 0;
  localparam int M1 = 1;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/iomem_rr_pick.sv
// Module iomem_rr_pick
// Purpose: combinational two-way round-robin picker.
// Ports:
//   req    in  2  request vector, bit M0 = master 0, bit M1 = master 1
//   last   in  2  one-hot owner of the previous grant
//   winner out 2  one-hot winner; 0 when nobody requests
module iomem_rr_pick
  import picosoc_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] last,
  output logic [1:0] winner
);

  always_comb begin
    winner = GRANT_NONE;
    if (req == 2'b11) begin
      // Contention: the master that did not own the last grant wins
      winner = last[M0] ? GRANT_M1 : GRANT_M0;
    end else begin
      // Zero or one requester: the request vector is already one-hot
      winner = req;
    end
  end

endmodule

// File: rtl/iomem_arbiter.sv
// Module iomem_arbiter
// Purpose: shares the picosoc iomem bus between master 0 (CPU) and master 1
//   (auxiliary DMA / LED sequencer). Round-robin grant, one outstanding
//   transaction, registered slave-side request, one-cycle ready pulse back
//   to the granted master.
// Optional feature: define IOMEM_ARB_TIMEOUT_EN to force completion of a
//   transaction after TIMEOUT_CYCLES cycles in BUSY, returning TIMEOUT_RDATA
//   and raising the sticky timeout_err flag (cleared by err_clr).
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   m0_valid/ready/addr/wdata/wstrb/rdata   master 0 iomem port
//   m1_valid/ready/addr/wdata/wstrb/rdata   master 1 iomem port
//   s_valid/ready/addr/wdata/wstrb/rdata    port towards the address decoder
//   grant        one-hot owner of the current transaction, 0 when idle
//   timeout_err  sticky timeout flag (constant 0 without the feature)
//   err_clr      clears timeout_err
module iomem_arbiter
  import picosoc_bus_pkg::*;
#(
  parameter int                  TIMEOUT_CYCLES = 1024,
  parameter logic [IOMEM_DW-1:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
  input  logic                clk,
  input  logic                resetn,

  input  logic                m0_valid,
  output logic                m0_ready,
  input  logic [IOMEM_AW-1:0] m0_addr,
  input  logic [IOMEM_DW-1:0] m0_wdata,
  input  logic [IOMEM_SW-1:0] m0_wstrb,
  output logic [IOMEM_DW-1:0] m0_rdata,

  input  logic                m1_valid,
  output logic                m1_ready,
  input  logic [IOMEM_AW-1:0] m1_addr,
  input  logic [IOMEM_DW-1:0] m1_wdata,
  input  logic [IOMEM_SW-1:0] m1_wstrb,
  output logic [IOMEM_DW-1:0] m1_rdata,

  output logic                s_valid,
  input  logic                s_ready,
  output logic [IOMEM_AW-1:0] s_addr,
  output logic [IOMEM_DW-1:0] s_wdata,
  output logic [IOMEM_SW-1:0] s_wstrb,
  input  logic [IOMEM_DW-1:0] s_rdata,

  output logic [1:0]          grant,
  output logic                timeout_err,
  input  logic                err_clr
);

  arb_state_e          state_reg, state_next;
  logic                s_valid_reg, s_valid_next;
  logic [IOMEM_AW-1:0] s_addr_reg, s_addr_next;
  logic [IOMEM_DW-1:0] s_wdata_reg, s_wdata_next;
  logic [IOMEM_SW-1:0] s_wstrb_reg, s_wstrb_next;
  logic [1:0]          grant_reg, grant_next;
  logic [1:0]          last_grant_reg, last_grant_next;

  logic [1:0]          winner;
  logic                timeout_hit;
  logic                complete;
  logic [IOMEM_DW-1:0] resp_data;
  logic [1:0]          ready_vec;
  logic [1:0][IOMEM_DW-1:0] rdata_vec;

  iomem_rr_pick u_pick (
    .req    ({m1_valid, m0_valid}),
    .last   (last_grant_reg),
    .winner (winner)
  );

  // A real s_ready always beats a timeout in the same cycle
  assign complete  = (state_reg == BUSY) && (s_ready || timeout_hit);
  assign resp_data = s_ready ? s_rdata : TIMEOUT_RDATA;

`ifdef IOMEM_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic          err_reg, err_next;

  assign timeout_hit = (state_reg == BUSY) && !s_ready && (cnt_reg == CNT_LAST);

  always_comb begin
    cnt_next = cnt_reg;
    err_next = err_reg;
    // Held at zero outside BUSY so every transaction starts counting from 0
    if (state_reg == BUSY) cnt_next = cnt_reg + 1'b1;
    else                   cnt_next = '0;
    if (timeout_hit)  err_next = 1'b1;
    else if (err_clr) err_next = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      err_reg <= err_next;
    end
  end

  assign timeout_err = err_reg;
`else
  logic unused_cfg;
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_cfg  = ^{err_clr, 32'(TIMEOUT_CYCLES)};
`endif

  // Arbiter FSM: next-state and slave-side request
  always_comb begin
    state_next      = state_reg;
    s_valid_next    = s_valid_reg;
    s_addr_next     = s_addr_reg;
    s_wdata_next    = s_wdata_reg;
    s_wstrb_next    = s_wstrb_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (winner != GRANT_NONE) begin
          s_valid_next    = 1'b1;
          s_addr_next     = winner[M1] ? m1_addr  : m0_addr;
          s_wdata_next    = winner[M1] ? m1_wdata : m0_wdata;
          s_wstrb_next    = winner[M1] ? m1_wstrb : m0_wstrb;
          grant_next      = winner;
          last_grant_next = winner;
          state_next      = BUSY;
        end
      end
      BUSY: begin
        if (complete) begin
          s_valid_next = 1'b0;
          state_next   = RESP;
        end
      end
      RESP: begin
        // Master drops its valid on this edge; IDLE then sees fresh requests
        grant_next = GRANT_NONE;
        state_next = IDLE;
      end
      default: begin
        s_valid_next = 1'b0;
        grant_next   = GRANT_NONE;
        state_next   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      s_valid_reg    <= 1'b0;
      s_addr_reg     <= '0;
      s_wdata_reg    <= '0;
      s_wstrb_reg    <= '0;
      grant_reg      <= GRANT_NONE;
      last_grant_reg <= GRANT_M1;  // so master 0 wins the first tie
    end else begin
      state_reg      <= state_next;
      s_valid_reg    <= s_valid_next;
      s_addr_reg     <= s_addr_next;
      s_wdata_reg    <= s_wdata_next;
      s_wstrb_reg    <= s_wstrb_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // Per-master response: one-cycle ready pulse with data; both read as zero
  // outside the pulse so the non-granted master never sees stale data.
  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    logic                ready_reg;
    logic [IOMEM_DW-1:0] rdata_reg;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        ready_reg <= 1'b0;
        rdata_reg <= '0;
      end else if (complete && grant_reg[gi]) begin
        ready_reg <= 1'b1;
        rdata_reg <= resp_data;
      end else begin
        ready_reg <= 1'b0;
        rdata_reg <= '0;
      end
    end

    assign ready_vec[gi] = ready_reg;
    assign rdata_vec[gi] = rdata_reg;
  end

  assign m0_ready = ready_vec[M0];
  assign m1_ready = ready_vec[M1];
  assign m0_rdata = rdata_vec[M0];
  assign m1_rdata = rdata_vec[M1];

  assign s_valid = s_valid_reg;
  assign s_addr  = s_addr_reg;
  assign s_wdata = s_wdata_reg;
  assign s_wstrb = s_wstrb_reg;
  assign grant   = grant_reg;

endmodule

// File: tb/tb_iomem_arbiter.sv
// Testbench for iomem_arbiter: scenario tasks with randomized requests and
// slave latencies, checked against a round-robin reference model.
module tb_iomem_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic        s_ready = 1'b0;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata = '0;
  logic [1:0]  grant;
  logic        timeout_err;
  logic        err_clr = 1'b0;

  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [1:0] model_last;

  always #5 clk = ~clk;

  iomem_arbiter #(.TIMEOUT_CYCLES(16), .TIMEOUT_RDATA(32'hDEADBEEF)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  function automatic req_t rand_req();
    req_t r;
    r.addr  = {8'($urandom_range(3, 5)), 24'($urandom)};
    r.wdata = $urandom;
    r.wstrb = 4'($urandom);
    return r;
  endfunction

  task automatic drive_m0(input logic v, input req_t r);
    m0_valid = v; m0_addr = r.addr; m0_wdata = r.wdata; m0_wstrb = r.wstrb;
  endtask

  task automatic drive_m1(input logic v, input req_t r);
    m1_valid = v; m1_addr = r.addr; m1_wdata = r.wdata; m1_wstrb = r.wstrb;
  endtask

  // Returns the number of negedges until s_valid is seen high, -1 if never
  task automatic wait_s_valid(output int waited);
    waited = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (s_valid === 1'b1) begin
        waited = i;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    m0_valid = 1'b0; m1_valid = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cmp_cnt++;
    if ({s_valid, grant, m0_ready, m1_ready, timeout_err} !== 6'b0) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got s_valid=%b grant=%b m0_ready=%b m1_ready=%b timeout_err=%b, want all 0",
               s_valid, grant, m0_ready, m1_ready, timeout_err);
    end
    cmp_cnt++;
    if ({m0_rdata, m1_rdata} !== 64'h0) begin
      err_cnt++;
      $display("FAIL reset_rdata: got m0=%h m1=%h, want 0", m0_rdata, m1_rdata);
    end
    cmp_cnt++;
    if ({s_addr, s_wdata, s_wstrb} !== 68'h0) begin
      err_cnt++;
      $display("FAIL reset_sbus: got addr=%h wdata=%h wstrb=%h, want 0", s_addr, s_wdata, s_wstrb);
    end
    resetn = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    req_t r;
    int w;
    r = rand_req();
    r.wstrb = 4'b0000;
    drive_m0(1'b1, r);
    wait_s_valid(w);
    cmp_cnt++;
    if (w !== 1) begin
      err_cnt++;
      $display("FAIL read_latency: got %0d cycles, want 1", w);
    end
    cmp_cnt++;
    if (grant !== 2'b01 || s_addr !== r.addr || s_wstrb !== 4'b0000) begin
      err_cnt++;
      $display("FAIL read_request: got grant=%b addr=%h wstrb=%h, want 01 %h 0", grant, s_addr, s_wstrb, r.addr);
    end
    @(negedge clk);
    @(negedge clk);
    s_ready = 1'b1; s_rdata = 32'h12345678;
    @(negedge clk);
    s_ready = 1'b0; s_rdata = $urandom;
    cmp_cnt++;
    if (m0_ready !== 1'b1 || m0_rdata !== 32'h12345678 || m1_ready !== 1'b0 || s_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL read_response: got m0_ready=%b m0_rdata=%h m1_ready=%b s_valid=%b, want 1 12345678 0 0",
               m0_ready, m0_rdata, m1_ready, s_valid);
    end
    m0_valid = 1'b0;
    @(negedge clk);
    cmp_cnt++;
    if (m0_ready !== 1'b0 || grant !== 2'b00) begin
      err_cnt++;
      $display("FAIL read_pulse_end: got m0_ready=%b grant=%b, want 0 00", m0_ready, grant);
    end
    $display("test_single_read addr=%h rdata=%h", r.addr, m0_rdata);
  endtask

  task automatic test_write_m1();
    req_t r;
    int w;
    logic [31:0] rd;
    r.addr = 32'h03000000; r.wdata = 32'h000000A5; r.wstrb = 4'b0001;
    drive_m1(1'b1, r);
    wait_s_valid(w);
    cmp_cnt++;
    if (w !== 1 || grant !== 2'b10) begin
      err_cnt++;
      $display("FAIL write_grant: got latency=%0d grant=%b, want 1 10", w, grant);
    end
    for (int i = 0; i < 3; i++) begin
      cmp_cnt++;
      if ({s_valid, s_addr, s_wdata, s_wstrb} !== {1'b1, r.addr, r.wdata, r.wstrb}) begin
        err_cnt++;
        $display("FAIL write_stable: cycle %0d got v=%b addr=%h wdata=%h wstrb=%h, want 1 %h %h %h",
                 i, s_valid, s_addr, s_wdata, s_wstrb, r.addr, r.wdata, r.wstrb);
      end
      if (i < 2) @(negedge clk);
    end
    rd = $urandom;
    s_ready = 1'b1; s_rdata = rd;
    @(negedge clk);
    s_ready = 1'b0;
    cmp_cnt++;
    if (m1_ready !== 1'b1 || m1_rdata !== rd || m0_ready !== 1'b0 || m0_rdata !== 32'h0) begin
      err_cnt++;
      $display("FAIL write_response: got m1_ready=%b m1_rdata=%h m0_ready=%b m0_rdata=%h, want 1 %h 0 0",
               m1_ready, m1_rdata, m0_ready, m0_rdata, rd);
    end
    m1_valid = 1'b0;
    @(negedge clk);
    $display("test_write_m1 addr=%h wdata=%h", r.addr, r.wdata);
  endtask

  task automatic test_idle_ready_ignored();
    s_ready = 1'b1; s_rdata = $urandom;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cmp_cnt++;
      if ({m0_ready, m1_ready, s_valid, grant} !== 5'b0) begin
        err_cnt++;
        $display("FAIL idle_s_ready: got m0_ready=%b m1_ready=%b s_valid=%b grant=%b, want all 0",
                 m0_ready, m1_ready, s_valid, grant);
      end
    end
    s_ready = 1'b0;
    @(negedge clk);
    $display("test_idle_ready_ignored done");
  endtask

  task automatic test_back_to_back();
    req_t q0[$];
    req_t q1[$];
    req_t head;
    logic [1:0]  exp_g;
    logic [31:0] rd;
    int w, lat, n, txn;
    apply_reset();
    model_last = 2'b10;
    n = $urandom_range(3, 5);
    for (int i = 0; i < n; i++) q0.push_back(rand_req());
    n = $urandom_range(3, 5);
    for (int i = 0; i < n; i++) q1.push_back(rand_req());
    drive_m0(1'b1, q0[0]);
    drive_m1(1'b1, q1[0]);
    txn = 0;
    while (q0.size() + q1.size() > 0) begin
      wait_s_valid(w);
      cmp_cnt++;
      if (w < 0 || (txn > 0 && w < 2)) begin
        err_cnt++;
        $display("FAIL b2b_gap: txn %0d s_valid after %0d cycles, want >=2 (idle gap)", txn, w);
        if (w < 0) break;
      end
      // Round-robin rule: alternate under contention, otherwise the sole requester
      if (q0.size() > 0 && q1.size() > 0) exp_g = (model_last == 2'b01) ? 2'b10 : 2'b01;
      else exp_g = (q0.size() > 0) ? 2'b01 : 2'b10;
      head = exp_g[0] ? q0[0] : q1[0];
      cmp_cnt++;
      if (grant !== exp_g || s_addr !== head.addr || s_wdata !== head.wdata || s_wstrb !== head.wstrb) begin
        err_cnt++;
        $display("FAIL b2b_grant: txn %0d got grant=%b addr=%h wdata=%h wstrb=%h, want %b %h %h %h",
                 txn, grant, s_addr, s_wdata, s_wstrb, exp_g, head.addr, head.wdata, head.wstrb);
      end
      lat = $urandom_range(0, 3);
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        cmp_cnt++;
        if (s_valid !== 1'b1 || grant !== exp_g || s_addr !== head.addr) begin
          err_cnt++;
          $display("FAIL b2b_stable: txn %0d got v=%b grant=%b addr=%h, want 1 %b %h",
                   txn, s_valid, grant, s_addr, exp_g, head.addr);
        end
      end
      rd = $urandom;
      s_ready = 1'b1; s_rdata = rd;
      @(negedge clk);
      s_ready = 1'b0;
      cmp_cnt++;
      if (exp_g[0] ? (m0_ready !== 1'b1 || m0_rdata !== rd || m1_ready !== 1'b0)
                   : (m1_ready !== 1'b1 || m1_rdata !== rd || m0_ready !== 1'b0)) begin
        err_cnt++;
        $display("FAIL b2b_response: txn %0d got m0_ready=%b m0_rdata=%h m1_ready=%b m1_rdata=%h, want owner %b data %h",
                 txn, m0_ready, m0_rdata, m1_ready, m1_rdata, exp_g, rd);
      end
      $display("b2b txn %0d grant=%b addr=%h lat=%0d rdata=%h", txn, exp_g, head.addr, lat, rd);
      model_last = exp_g;
      if (exp_g[0]) begin
        void'(q0.pop_front());
        if (q0.size() > 0) drive_m0(1'b1, q0[0]); else m0_valid = 1'b0;
      end else begin
        void'(q1.pop_front());
        if (q1.size() > 0) drive_m1(1'b1, q1[0]); else m1_valid = 1'b0;
      end
      txn++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_busy();
    req_t r0, r1;
    int w;
    r0 = rand_req();
    drive_m0(1'b1, r0);
    wait_s_valid(w);
    @(negedge clk);
    // m0 owns the bus now, so without reset the next tie would go to m1
    resetn = 1'b0;
    #1;
    cmp_cnt++;
    if ({s_valid, grant, m0_ready, m1_ready} !== 5'b0) begin
      err_cnt++;
      $display("FAIL async_reset: got s_valid=%b grant=%b m0_ready=%b m1_ready=%b, want all 0",
               s_valid, grant, m0_ready, m1_ready);
    end
    @(negedge clk);
    r0 = rand_req(); r1 = rand_req();
    drive_m0(1'b1, r0); drive_m1(1'b1, r1);
    resetn = 1'b1;
    wait_s_valid(w);
    cmp_cnt++;
    if (w !== 1 || grant !== 2'b01 || s_addr !== r0.addr) begin
      err_cnt++;
      $display("FAIL reset_tie: got latency=%0d grant=%b addr=%h, want 1 01 %h", w, grant, s_addr, r0.addr);
    end
    s_ready = 1'b1; s_rdata = 32'h0;
    @(negedge clk);
    s_ready = 1'b0; m0_valid = 1'b0;
    wait_s_valid(w);
    cmp_cnt++;
    if (grant !== 2'b10 || s_addr !== r1.addr) begin
      err_cnt++;
      $display("FAIL reset_second: got grant=%b addr=%h, want 10 %h", grant, s_addr, r1.addr);
    end
    s_ready = 1'b1;
    @(negedge clk);
    s_ready = 1'b0; m1_valid = 1'b0;
    @(negedge clk);
    $display("test_reset_busy done");
  endtask

`ifdef IOMEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    req_t r;
    int w, c;
    logic [31:0] rd;
    r = rand_req();
    drive_m0(1'b1, r);
    wait_s_valid(w);
    c = 0;
    while (c < 40) begin
      @(negedge clk);
      c++;
      if (m0_ready === 1'b1) break;
    end
    cmp_cnt++;
    if (c !== 16 || m0_rdata !== 32'hDEADBEEF || timeout_err !== 1'b1) begin
      err_cnt++;
      $display("FAIL timeout_fire: got %0d cycles rdata=%h err=%b, want 16 deadbeef 1", c, m0_rdata, timeout_err);
    end
    m0_valid = 1'b0;
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if (timeout_err !== 1'b1) begin
      err_cnt++;
      $display("FAIL timeout_sticky: got err=%b, want 1", timeout_err);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    cmp_cnt++;
    if (timeout_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL timeout_clear: got err=%b, want 0", timeout_err);
    end
    r = rand_req();
    drive_m1(1'b1, r);
    wait_s_valid(w);
    repeat (15) @(negedge clk);
    rd = $urandom;
    s_ready = 1'b1; s_rdata = rd;
    @(negedge clk);
    s_ready = 1'b0;
    cmp_cnt++;
    if (m1_ready !== 1'b1 || m1_rdata !== rd || timeout_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL timeout_race: got m1_ready=%b rdata=%h err=%b, want 1 %h 0", m1_ready, m1_rdata, timeout_err, rd);
    end
    m1_valid = 1'b0;
    @(negedge clk);
    $display("test_timeout done");
  endtask
`else
  task automatic test_no_timeout();
    req_t r;
    int w;
    logic [31:0] rd;
    r = rand_req();
    drive_m0(1'b1, r);
    wait_s_valid(w);
    repeat (40) @(negedge clk);
    cmp_cnt++;
    if (m0_ready !== 1'b0 || s_valid !== 1'b1 || timeout_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL no_timeout: got m0_ready=%b s_valid=%b err=%b, want 0 1 0", m0_ready, s_valid, timeout_err);
    end
    rd = $urandom;
    s_ready = 1'b1; s_rdata = rd;
    @(negedge clk);
    s_ready = 1'b0;
    cmp_cnt++;
    if (m0_ready !== 1'b1 || m0_rdata !== rd) begin
      err_cnt++;
      $display("FAIL no_timeout_done: got m0_ready=%b rdata=%h, want 1 %h", m0_ready, m0_rdata, rd);
    end
    m0_valid = 1'b0;
    @(negedge clk);
    $display("test_no_timeout done");
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_write_m1();
    test_idle_ready_ignored();
    test_back_to_back();
    test_reset_busy();
`ifdef IOMEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
